// File: rtl/axis_pkg.sv
// Shared helpers for the block buffer: safe widths, beats-per-block and framing counter layout.
package axis_pkg;

  localparam int CNT_W = 16;

  function automatic int clog2w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int bpb(input int bdim, input int pe);
    return bdim / pe;
  endfunction

  typedef struct packed {
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] blk_cnt;
  } frame_cnt_t;

endpackage

// File: rtl/axis_fifo_fwft.sv
// First-word fall-through FIFO, one cycle from push to visible head.
// rdy_o is registered !full, so it never depends combinationally on pop_i.
module axis_fifo_fwft #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wr_dat_i,
  output logic [DATA_W-1:0]        rd_dat_o,
  output logic                     empty_o,
  output logic                     rdy_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              rdy_q;
  logic              full_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    // Full when the indices match but the wrap bits differ.
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= !full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end

  assign rd_dat_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign rdy_o       = rdy_q;
  assign occupancy_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/axis_block_buffer.sv
// AXI-Stream block buffer: FWFT FIFO plus block/stream framing; 1-cycle latency.
// Input ready is registered !full; clear blanks both handshakes for its cycle.
module axis_block_buffer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int PE               = 2,
  parameter int DEPTH            = 4,
  parameter int s_axis_data_BDIM = 4,
  parameter int s_axis_data_SDIM = 16
) (
  input  logic                                                  ap_clk,
  input  logic                                                  ap_rst,
  input  logic                                                  clear,
  input  logic [PE*DATA_WIDTH-1:0]                              s_axis_data_tdata,
  input  logic                                                  s_axis_data_tvalid,
  output logic                                                  s_axis_data_tready,
  output logic [PE*DATA_WIDTH-1:0]                              m_axis_result_tdata,
  output logic                                                  m_axis_result_tvalid,
  input  logic                                                  m_axis_result_tready,
  output logic                                                  m_axis_result_tlast,
  output logic                                                  m_axis_result_tuser,
  output logic [clog2w(s_axis_data_SDIM/s_axis_data_BDIM)-1:0]  block_idx,
  output logic [$clog2(DEPTH):0]                                occupancy
);

  localparam int BPB    = bpb(s_axis_data_BDIM, PE);
  localparam int NBLK   = s_axis_data_SDIM / s_axis_data_BDIM;
  localparam int BIDX_W = clog2w(NBLK);

  if (PE < 1 || s_axis_data_BDIM < PE || (s_axis_data_BDIM % PE) != 0) begin : g_bad_bdim
    $error("s_axis_data_BDIM must be a positive multiple of PE");
  end
  if (s_axis_data_SDIM < s_axis_data_BDIM || (s_axis_data_SDIM % s_axis_data_BDIM) != 0) begin : g_bad_sdim
    $error("s_axis_data_SDIM must be a positive multiple of s_axis_data_BDIM");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end
  if (BPB >= (1 << CNT_W) || NBLK >= (1 << CNT_W)) begin : g_bad_cnt
    $error("framing counts exceed counter width");
  end

  frame_cnt_t frm_q, frm_d;
  logic       fifo_rdy, fifo_empty;
  logic       push, pop;
  logic       last_beat, last_blk;

  assign s_axis_data_tready   = fifo_rdy && !clear;
  assign push                 = s_axis_data_tvalid && s_axis_data_tready;
  assign m_axis_result_tvalid = !fifo_empty && !clear;
  assign pop                  = m_axis_result_tvalid && m_axis_result_tready;

  axis_fifo_fwft #(
    .DATA_W (PE*DATA_WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (ap_clk),
    .rst_i       (ap_rst),
    .clear_i     (clear),
    .push_i      (push),
    .pop_i       (pop),
    .wr_dat_i    (s_axis_data_tdata),
    .rd_dat_o    (m_axis_result_tdata),
    .empty_o     (fifo_empty),
    .rdy_o       (fifo_rdy),
    .occupancy_o (occupancy)
  );

  assign last_beat = (frm_q.beat_cnt == CNT_W'(BPB - 1));
  assign last_blk  = (frm_q.blk_cnt == CNT_W'(NBLK - 1));

  // Counters move only on pop, so framing holds steady under backpressure.
  always_comb begin
    frm_d = frm_q;
    if (clear) begin
      frm_d = '0;
    end else if (pop) begin
      if (last_beat) begin
        frm_d.beat_cnt = '0;
        frm_d.blk_cnt  = last_blk ? '0 : frm_q.blk_cnt + CNT_W'(1);
      end else begin
        frm_d.beat_cnt = frm_q.beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) frm_q <= '0;
    else        frm_q <= frm_d;
  end

  assign m_axis_result_tlast = m_axis_result_tvalid && last_beat;
  assign m_axis_result_tuser = m_axis_result_tlast && last_blk;
  assign block_idx           = frm_q.blk_cnt[BIDX_W-1:0];

endmodule

// File: tb/tb_axis_block_buffer.sv
// Scoreboard bench for axis_block_buffer: directed phases plus randomized traffic.
module tb_axis_block_buffer;

  localparam int DW    = 32;
  localparam int PE    = 2;
  localparam int DEPTH = 4;
  localparam int BDIM  = 4;
  localparam int SDIM  = 16;
  localparam int W     = PE*DW;

  logic           ap_clk = 1'b0;
  logic           ap_rst = 1'b0;
  logic           clear = 1'b0;
  logic [W-1:0]   s_axis_data_tdata = '0;
  logic           s_axis_data_tvalid = 1'b0;
  logic           s_axis_data_tready;
  logic [W-1:0]   m_axis_result_tdata;
  logic           m_axis_result_tvalid;
  logic           m_axis_result_tready = 1'b0;
  logic           m_axis_result_tlast;
  logic           m_axis_result_tuser;
  logic [1:0]     block_idx;
  logic [2:0]     occupancy;

  axis_block_buffer #(
    .DATA_WIDTH(DW), .PE(PE), .DEPTH(DEPTH),
    .s_axis_data_BDIM(BDIM), .s_axis_data_SDIM(SDIM)
  ) dut (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .clear                (clear),
    .s_axis_data_tdata    (s_axis_data_tdata),
    .s_axis_data_tvalid   (s_axis_data_tvalid),
    .s_axis_data_tready   (s_axis_data_tready),
    .m_axis_result_tdata  (m_axis_result_tdata),
    .m_axis_result_tvalid (m_axis_result_tvalid),
    .m_axis_result_tready (m_axis_result_tready),
    .m_axis_result_tlast  (m_axis_result_tlast),
    .m_axis_result_tuser  (m_axis_result_tuser),
    .block_idx            (block_idx),
    .occupancy            (occupancy)
  );

  always #5 ap_clk = ~ap_clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  int           n_pop = 0;
  bit           armed = 1'b0;
  int unsigned  beat_id = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ready may only rise on the first clock edge after reset is released.
  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) armed = 1'b0;
    else        armed = 1'b1;
  end

  // Monitor: compares DUT against the queue model mid-cycle.
  always @(negedge ap_clk) begin
    bit exp_v, exp_r;
    int elem_end;
    exp_v = !ap_rst && !clear && (exp_q.size() > 0);
    exp_r = !ap_rst && !clear && armed && (exp_q.size() < DEPTH);
    chk("occupancy", occupancy, ap_rst ? 0 : exp_q.size());
    chk("m_tvalid", m_axis_result_tvalid, exp_v);
    chk("s_tready", s_axis_data_tready, exp_r);
    if (exp_v && m_axis_result_tvalid) begin
      elem_end = (n_pop + 1) * PE;
      chk("tdata", m_axis_result_tdata, exp_q[0]);
      chk("tlast", m_axis_result_tlast, (elem_end % BDIM) == 0);
      chk("tuser", m_axis_result_tuser, (elem_end % SDIM) == 0);
      chk("block_idx", block_idx, ((n_pop * PE) % SDIM) / BDIM);
      if (m_axis_result_tready) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
    end
    if (s_axis_data_tvalid && s_axis_data_tready) exp_q.push_back(s_axis_data_tdata);
    if (ap_rst || clear) begin
      exp_q.delete();
      n_pop = 0;
    end
  end

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic new_beat();
    s_axis_data_tdata = {32'($urandom()), 32'(beat_id)};
    beat_id++;
  endtask

  // Offer up to n beats, giving up after max_cyc cycles.
  task automatic offer(input int n, input int max_cyc, output int sent);
    bit acc;
    sent = 0;
    new_beat();
    for (int c = 0; c < max_cyc && sent < n; c++) begin
      s_axis_data_tvalid = 1'b1;
      @(negedge ap_clk);
      acc = s_axis_data_tready;
      cyc();
      if (acc) begin
        sent++;
        new_beat();
      end
    end
    s_axis_data_tvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    bit acc;
    #1 ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("tready_before_edge", s_axis_data_tready, 0);
    cyc();
    chk("tready_after_rst", s_axis_data_tready, 1);

    // Back-to-back streaming.
    m_axis_result_tready = 1'b1;
    offer(8, 20, sent);
    chk("stream_sent", sent, 8);
    repeat (3) cyc();

    // Backpressure: only DEPTH beats fit.
    m_axis_result_tready = 1'b0;
    offer(6, 8, sent);
    chk("bp_accepted", sent, 4);
    chk("bp_occ", occupancy, 4);
    chk("bp_tready", s_axis_data_tready, 0);
    m_axis_result_tready = 1'b1;
    offer(2, 10, sent);
    chk("bp_rest", sent, 2);
    repeat (5) cyc();

    // Clear mid-block with two beats buffered.
    offer(3, 10, sent);
    cyc();
    m_axis_result_tready = 1'b0;
    offer(2, 10, sent);
    chk("clr_buffered", occupancy, 2);
    clear = 1'b1;
    s_axis_data_tvalid = 1'b1;
    new_beat();
    cyc();
    clear = 1'b0;
    s_axis_data_tvalid = 1'b0;
    chk("clr_occ", occupancy, 0);
    m_axis_result_tready = 1'b1;
    offer(1, 10, sent);
    cyc();

    // Hold rule: stall on a tlast beat.
    m_axis_result_tready = 1'b0;
    offer(1, 10, sent);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("hold_tlast", m_axis_result_tlast, 1);
      cyc();
    end
    m_axis_result_tready = 1'b1;
    cyc();

    // Two full streams from a clean counter state.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    offer(16, 40, sent);
    chk("wrap_sent", sent, 16);
    repeat (3) cyc();

    // Asynchronous reset between edges with two beats buffered.
    m_axis_result_tready = 1'b0;
    offer(2, 10, sent);
    #2 ap_rst = 1'b1;
    #1;
    chk("arst_tvalid", m_axis_result_tvalid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_tready", s_axis_data_tready, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    cyc();

    // Randomized traffic with occasional clear.
    new_beat();
    for (int i = 0; i < 600; i++) begin
      s_axis_data_tvalid   = ($urandom_range(0, 9) < 7);
      m_axis_result_tready = ($urandom_range(0, 9) < 6);
      clear                = ($urandom_range(0, 49) == 0);
      @(negedge ap_clk);
      acc = s_axis_data_tvalid && s_axis_data_tready;
      cyc();
      if (acc) new_beat();
    end
    clear = 1'b0;
    s_axis_data_tvalid = 1'b0;
    m_axis_result_tready = 1'b1;
    repeat (DEPTH + 2) cyc();
    chk("final_drain", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_block_buffer.md
Name: axis_block_buffer

Overview:
- Parametrised AXI-Stream block buffer for kernel-integrator data paths; successor to the single-register stream slice.
- Adds a PE-lane datapath, a DEPTH-entry FIFO and BDIM/SDIM framing counters.
- Sits between an input stream and a compute kernel. Emits tlast at every BDIM-element block boundary and tuser at every SDIM-element stream end.
- Missing or inconsistent BDIM/SDIM is an elaboration error.

Parameters:
DATA_WIDTH, 32, bits per element
PE, 2, elements per beat (lanes)
DEPTH, 4, FIFO entries; power of two, >=2
s_axis_data_BDIM, 4, elements per block; must be a multiple of PE
s_axis_data_SDIM, 16, elements per stream; must be a multiple of s_axis_data_BDIM

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous flush
s_axis_data_tdata  in  PE*DATA_WIDTH  input beat, lane 0 in LSBs
s_axis_data_tvalid  in  1  input valid
s_axis_data_tready  out  1  input ready
m_axis_result_tdata  out  PE*DATA_WIDTH  output beat
m_axis_result_tvalid  out  1  output valid
m_axis_result_tready  in  1  output ready
m_axis_result_tlast  out  1  last beat of block
m_axis_result_tuser  out  1  last beat of stream
block_idx  out  clog2(SDIM/BDIM) (min 1)  block index of current output beat
occupancy  out  clog2(DEPTH)+1  entries held

Behaviour:
- Derived constants: BPB = BDIM/PE beats per block; NBLK = SDIM/BDIM blocks per stream.
- Elaboration fails ($error) if BDIM%PE!=0, SDIM%BDIM!=0, or DEPTH is not a power of two >=2.
- Reset (ap_rst high, asynchronous): FIFO empty; all counters 0; tvalid/tlast/tuser 0; tready 0; block_idx 0; occupancy 0.
- s_axis_data_tready is registered. It rises on the first ap_clk edge after reset deasserts.
- Push happens when s tvalid && s tready; pop happens when m tvalid && m tready.
- s_axis_data_tready = registered !full_next.
  - No combinational path from m_axis_result_tready to s_axis_data_tready.
  - When full, a same-cycle pop does not allow a same-cycle push. tready reasserts the cycle after the pop.
- First-word fall-through with registered head: a beat accepted at edge N is valid on m_axis at edge N+1 when the FIFO was empty. Latency is 1 cycle.
- Simultaneous push and pop when not full: occupancy unchanged; order preserved.
- Data appears unmodified and in order.
- Framing counters advance on pop only:
  - beat_cnt 0..BPB-1.
  - blk_cnt 0..NBLK-1; increments when beat_cnt wraps.
  - Both wrap to 0 after the stream-end beat; the next beat starts a new stream.
- m_axis_result_tlast = tvalid && beat_cnt==BPB-1.
- m_axis_result_tuser = tlast && blk_cnt==NBLK-1.
- block_idx = blk_cnt.
- Framing outputs are stable while tvalid && !tready (AXI hold rule).
- clear has priority over push and pop:
  - In the clear cycle, s tready and m tvalid are forced 0 combinationally, so no handshake occurs.
  - At the edge, FIFO empties and counters zero.
- Async reset mid-stream: outputs drop immediately without a clock edge. Data in flight is discarded.
- occupancy counts the head register plus storage entries.
- occupancy==DEPTH implies s tready 0 on the next cycle; occupancy==0 implies m tvalid 0.

Decomposition:
- Package axis_pkg:
  - clog2-safe width function (minimum 1);
  - function bpb(BDIM,PE);
  - typedef for framing counter struct {beat_cnt, blk_cnt}.
- Sub-module axis_fifo_fwft (DATA_W, DEPTH):
  - storage, read/write pointers with an extra wrap bit, full/empty, occupancy, registered ready.
- Top holds framing counters, clear gating and parameter checks.

Test Plan:
- Reset: pulse ap_rst 3 cycles, then release -> during reset tvalid=0, tready=0, occupancy=0; tready=1 one edge after release.
- Streaming, PE=2, BDIM=4, SDIM=16, m tready=1, 8 back-to-back beats with tdata=0..7 -> output 0..7 at 1-cycle latency.
  - tlast on beats 1,3,5,7; tuser only on beat 7.
  - block_idx sequence 0,0,1,1,2,2,3,3; tready never drops.
- Backpressure: m tready=0, offer 6 beats -> exactly 4 accepted; tready=0; occupancy=4.
  - Raise m tready -> 0..3 drain in order; tready=1 the cycle after the first pop; remaining 2 beats follow.
- Hold rule: m tready=0 on beat 1 (tlast=1) -> tdata/tlast/block_idx stable for 5 cycles; tlast pulses once after acceptance.
- Clear mid-block: after 3 beats popped, with 2 buffered, pulse clear -> no handshake in that cycle; occupancy=0.
  - Next beat emitted has block_idx=0 and tlast=0.
- Wrap and async reset: stream 16 beats (two streams) -> second tuser on beat 15; block_idx restarts at 0 on beat 8.
  - Then assert ap_rst between clock edges with 2 beats buffered -> tvalid=0 and occupancy=0 immediately, before the next ap_clk edge.
